// File: rtl/cgra_mem_pkg.sv
// rtl/cgra_mem_pkg.sv - shared types and defaults for the CGRA tile data-memory path
package cgra_mem_pkg;

    localparam int CGRA_ADDR_W = 32;
    localparam int CGRA_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational find-first-set searching upward from a rotating pointer
module rr_picker #(
    parameter int NUM_PE = 4,
    parameter int IDX_W  = $clog2(NUM_PE)
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              valid
);

    // Walk offsets from highest to lowest so the smallest offset from ptr is kept last.
    always_comb begin
        int idx;
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PE) begin
                idx = idx - NUM_PE;
            end
            if (req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pe_mem_arbiter.sv
// rtl/pe_mem_arbiter.sv - round-robin share of one data-memory port among NUM_PE PEs
// Optional ack timeout with error pulse: define PE_MEM_ARB_TIMEOUT_EN.
module pe_mem_arbiter
    import cgra_mem_pkg::*;
#(
    parameter int NUM_PE  = 4,
    parameter int ADDR_W  = CGRA_ADDR_W,
    parameter int DATA_W  = CGRA_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PE-1:0]          pe_read,
    input  logic [NUM_PE-1:0]          pe_write,
    input  logic [NUM_PE*ADDR_W-1:0]   pe_address,
    input  logic [NUM_PE*DATA_W-1:0]   pe_wdata,
    output logic [NUM_PE-1:0]          pe_ack,
    output logic [NUM_PE-1:0]          pe_err,
    output logic [DATA_W-1:0]          pe_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ack,
    output logic [$clog2(NUM_PE)-1:0]  grant_id,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_PE);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  pick;
    logic              pick_valid;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [NUM_PE-1:0] grant_oh;
    logic              expire;

    rr_picker #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req    (pe_read | pe_write),
        .ptr    (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

`ifdef PE_MEM_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;

    // Held at zero outside BUSY, so it is already clear on the first BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ST_BUSY) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign expire = (state == ST_BUSY) && (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ST_BUSY) begin
            err_q <= !mem_ack && expire;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_valid) state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ack || expire) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write wins when a PE raises both read and write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_q    <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pick_valid) begin
                    grant_q    <= pick;
                    op_write_q <= pe_write[pick];
                    addr_q     <= pe_address[pick*ADDR_W +: ADDR_W];
                    wdata_q    <= pe_wdata[pick*DATA_W +: DATA_W];
                end
                ST_BUSY: if (mem_ack) begin
                    rdata_q <= mem_rdata;
                end else if (expire) begin
                    rdata_q <= '0;
                end
                ST_RESP: rr_ptr <= (grant_q == IDX_W'(NUM_PE - 1)) ? '0 : grant_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign grant_oh = {{(NUM_PE-1){1'b0}}, 1'b1} << grant_q;

    // Outputs decode the asynchronously reset state, so reset drops them immediately.
    always_comb begin
        busy        = (state != ST_IDLE);
        mem_read    = (state == ST_BUSY) && !op_write_q;
        mem_write   = (state == ST_BUSY) && op_write_q;
        mem_address = (state == ST_BUSY) ? addr_q : '0;
        mem_wdata   = (state == ST_BUSY) ? wdata_q : '0;
        pe_ack      = (state == ST_RESP) ? grant_oh : '0;
        pe_rdata    = (state == ST_RESP) ? rdata_q : '0;
        grant_id    = grant_q;
`ifdef PE_MEM_ARB_TIMEOUT_EN
        pe_err      = (state == ST_RESP && err_q) ? grant_oh : '0;
`else
        pe_err      = '0;
`endif
    end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// tb/tb_pe_mem_arbiter.sv - directed self-checking bench for pe_mem_arbiter
module tb_pe_mem_arbiter;

    localparam int NPE = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NPE-1:0]    pe_read, pe_write, pe_ack, pe_err;
    logic [NPE*AW-1:0] pe_address;
    logic [NPE*DW-1:0] pe_wdata;
    logic [DW-1:0]     pe_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_address;
    logic              mem_read, mem_write, mem_ack, busy;
    logic [1:0]        grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    pe_mem_arbiter #(
        .NUM_PE  (NPE),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_read     (pe_read),
        .pe_write    (pe_write),
        .pe_address  (pe_address),
        .pe_wdata    (pe_wdata),
        .pe_ack      (pe_ack),
        .pe_err      (pe_err),
        .pe_rdata    (pe_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pe_read    = '0;
        pe_write   = '0;
        pe_address = '0;
        pe_wdata   = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    int exp_order [4] = '{0, 1, 3, 0};

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("rst_busy", busy, 0);
        check("rst_ack", pe_ack, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_grant", grant_id, 0);
        do_reset();

        // Single read by PE2, ack in first BUSY cycle
        pe_read[2] = 1'b1;
        pe_address[2*AW +: AW] = 32'h40;
        check("rd_c0_mem_read", mem_read, 0);
        tick();
        check("rd_c1_mem_read", mem_read, 1);
        check("rd_c1_addr", mem_address, 32'h40);
        check("rd_c1_grant", grant_id, 2);
        check("rd_c1_busy", busy, 1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("rd_c2_mem_read", mem_read, 0);
        check("rd_c2_ack", pe_ack, 4'b0100);
        check("rd_c2_rdata", pe_rdata, 32'hDEADBEEF);
        check("rd_c2_err", pe_err, 0);
        mem_ack = 1'b0;
        pe_read[2] = 1'b0;
        tick();
        check("rd_c3_ack", pe_ack, 0);
        check("rd_c3_busy", busy, 0);

        // mem_ack while IDLE is ignored
        mem_ack = 1'b1;
        tick();
        check("stray_ack_busy", busy, 0);
        check("stray_ack_pe_ack", pe_ack, 0);
        mem_ack = 1'b0;

        // Round-robin among PEs 0, 1, 3 with immediate ack
        do_reset();
        for (int i = 0; i < NPE; i++) pe_address[i*AW +: AW] = 32'h100 + i;
        pe_read = 4'b1011;
        mem_ack = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rr_mem_read", mem_read, 1);
            check("rr_grant", grant_id, exp_order[n]);
            check("rr_addr", mem_address, 32'h100 + exp_order[n]);
            tick();
            check("rr_ack", pe_ack, 32'(1) << exp_order[n]);
            pe_read[exp_order[n]] = 1'b0;
            tick();
            check("rr_idle", busy, 0);
            pe_read[exp_order[n]] = 1'b1;
        end
        clear_inputs();
        tick();

        // Read+write conflict on PE1, request changed mid-BUSY
        do_reset();
        pe_read[1]  = 1'b1;
        pe_write[1] = 1'b1;
        pe_address[1*AW +: AW] = 32'h10;
        pe_wdata[1*DW +: DW]   = 32'h5;
        tick();
        check("rw_mem_write", mem_write, 1);
        check("rw_mem_read", mem_read, 0);
        check("rw_addr", mem_address, 32'h10);
        check("rw_wdata", mem_wdata, 32'h5);
        pe_read[1]  = 1'b0;
        pe_write[1] = 1'b0;
        pe_address[1*AW +: AW] = 32'h99;
        tick();
        check("rw_latched_addr", mem_address, 32'h10);
        check("rw_latched_write", mem_write, 1);
        mem_ack = 1'b1;
        tick();
        check("rw_ack", pe_ack, 4'b0010);
        mem_ack = 1'b0;
        tick();

        // Reset mid-BUSY, then PE0 beats PE3 from rr_ptr=0
        do_reset();
        pe_write[2] = 1'b1;
        pe_address[2*AW +: AW] = 32'h77;
        tick();
        check("mid_pre_write", mem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_write", mem_write, 0);
        check("mid_async_busy", busy, 0);
        check("mid_async_addr", mem_address, 0);
        check("mid_async_grant", grant_id, 0);
        clear_inputs();
        @(posedge clk);
        #3 rst_n = 1'b1;
        pe_read = 4'b1001;
        tick();
        check("post_rst_grant", grant_id, 0);
        check("post_rst_read", mem_read, 1);
        mem_ack = 1'b1;
        tick();
        check("post_rst_ack", pe_ack, 4'b0001);
        clear_inputs();
        tick();

`ifdef PE_MEM_ARB_TIMEOUT_EN
        // Memory never acks: expiry after 8 BUSY cycles
        do_reset();
        pe_read[3] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("to_busy_read", mem_read, 1);
        end
        tick();
        check("to_ack", pe_ack, 4'b1000);
        check("to_err", pe_err, 4'b1000);
        check("to_rdata", pe_rdata, 0);
        check("to_strobe", mem_read, 0);
        pe_read[3] = 1'b0;
        tick();

        // Ack coinciding with expiry completes normally
        do_reset();
        pe_read[3] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("to2_busy_read", mem_read, 1);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h1234;
        tick();
        check("to2_ack", pe_ack, 4'b1000);
        check("to2_err", pe_err, 0);
        check("to2_rdata", pe_rdata, 32'h1234);
        clear_inputs();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mem_arbiter.md
# pe_mem_arbiter

Shares the single data-memory port of a CGRA tile among `NUM_PE` RISC-V PE controllers. Each PE presents its existing level-held `mem_read`/`mem_write`/`mem_address` request and waits for `mem_ack`. The arbiter grants one requester at a time in round-robin order, drives the memory port, and returns a one-cycle acknowledge with read data to the winning PE. It sits between the PE controllers and the tile memory.

## Interface
Parameters:
- `NUM_PE`, 4: number of requesting PEs (2..16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum cycles spent waiting for `mem_ack`; used only with the timeout feature.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pe_read`  in  NUM_PE  per-PE read request, held until acked.
- `pe_write`  in  NUM_PE  per-PE write request, held until acked.
- `pe_address`  in  NUM_PE*ADDR_W  packed addresses; PE i occupies slice i.
- `pe_wdata`  in  NUM_PE*DATA_W  packed write data.
- `pe_ack`  out  NUM_PE  one-cycle completion pulse to the granted PE.
- `pe_err`  out  NUM_PE  one-cycle error pulse, coincident with `pe_ack`.
- `pe_rdata`  out  DATA_W  shared read data, valid only while any `pe_ack` bit is 1.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_address`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, sampled when `mem_ack` is 1.
- `mem_ack`  in  1  memory completion.
- `grant_id`  out  $clog2(NUM_PE)  index of the current or last winner.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- Request vector: `req[i] = pe_read[i] | pe_write[i]`. If both are high for one PE, the request is serviced as a write.
- IDLE: if any `req` bit is set, pick the first set bit searching upward from `rr_ptr` with wrap-around. Register the winner into `grant_id` along with its op, address and wdata. Go to BUSY.
- BUSY: drive `mem_read`/`mem_write`, `mem_address` and `mem_wdata` from the latched values. On `mem_ack`=1:
  - capture `mem_rdata`; writes capture it too, but the value is don't-care;
  - drop the `mem_*` strobes;
  - go to RESP.
- RESP: `pe_ack[grant_id]`=1 and `pe_rdata` holds the captured data. Set `rr_ptr = (grant_id+1) mod NUM_PE` and go to IDLE.
- Requests are latched at grant. A PE that drops or changes its request during BUSY does not alter the transaction, and its ack is still pulsed.
- A PE must drop its request at the edge following its `pe_ack`. IDLE evaluates only after that edge, so the same PE is never double-granted.
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0. All outputs are 0: `pe_ack`, `pe_err`, `pe_rdata`, `mem_*`, `busy`.
- Reset asserted mid-transaction abandons it immediately. No ack is issued and the memory strobes drop asynchronously.

## Timing
- Request visible in cycle 0 (IDLE): `mem_*` strobe is high in cycle 1.
- `mem_ack` in cycle k (k≥1): `pe_ack` is high in cycle k+1 and the arbiter is back in IDLE in cycle k+2.
- Minimum request-to-ack latency is 2 cycles. Back-to-back grants to different PEs are spaced by at least 3 cycles.
- `mem_ack` arriving outside BUSY is ignored.
- `pe_ack` is always one-hot or zero and never lasts longer than 1 cycle.

## Configuration
- `PE_MEM_ARB_TIMEOUT_EN` defined:
  - an 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle;
  - if it reaches `TIMEOUT` with no `mem_ack`, the strobes drop and the FSM goes to RESP with `pe_ack` and `pe_err` both pulsed for the winner and `pe_rdata`=0;
  - `mem_ack` in the same cycle as expiry wins, so the transaction completes normally with no error.
- Not defined: `pe_err` is tied to 0, BUSY waits indefinitely, and `TIMEOUT` is unused.

## Structure
- Package `cgra_mem_pkg`:
  - FSM state enum (IDLE, BUSY, RESP);
  - default `ADDR_W`/`DATA_W` constants shared with the PE controller.
- Sub-module `rr_picker`: combinational find-first-set from a rotating pointer, producing a winner index and a valid flag. Parameterised by `NUM_PE`.

## Test plan
- Single read: PE2 requests read at 0x40 and memory acks in the first BUSY cycle with 0xDEADBEEF → `mem_read` high 1 cycle, then `pe_ack`=0b0100 with `pe_rdata`=0xDEADBEEF, 2 cycles after the request.
- Round-robin: PEs 0, 1 and 3 request continuously with immediate ack → grant order 0, 1, 3, 0, with no PE granted twice while another waits.
- Read+write conflict: PE1 asserts both, address 0x10, wdata 0x5 → `mem_write`=1 and `mem_read`=0.
- Reset mid-BUSY: assert `rst_n`=0 while `mem_write`=1 → all outputs drop to 0 asynchronously. After release, `rr_ptr`=0, so PE0 wins a simultaneous PE0/PE3 request.
- Timeout (macro on, `TIMEOUT`=8): memory never acks → `pe_ack` and `pe_err` for the winner pulse after 8 BUSY cycles with `pe_rdata`=0. A second run with ack in cycle 8 gives no error.
